// File: rtl/accel_seq_ctrl.sv
// Operand/result sequencer for the shared 8-bit byte multiplier.
// Walks every byte lane of the operand words once per job, then waits for the
// multiplier pipeline to drain before flagging completion. The result strobes
// are the operand strobes delayed through a MUL_LAT-deep shift pipeline.
//
// state | meaning
// IDLE  | waiting for an accepted start; done/cycle_cnt/indices hold
// RUN   | issuing one operand select per cycle, 4*NWORDS in total
// DRAIN | operands finished, waiting MUL_LAT cycles for last products
module accel_seq_ctrl #(
  parameter int NWORDS  = 4,
  parameter int MUL_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     abort,
  output logic                                     busy,
  output logic                                     done,
  output logic [CNT_W-1:0]                         cycle_cnt,
  output logic                                     op_valid,
  output logic [((NWORDS > 1) ? $clog2(NWORDS) : 1)-1:0] op_word,
  output logic [1:0]                               op_byte,
  output logic                                     res_we,
  output logic [((NWORDS > 1) ? $clog2(NWORDS) : 1)-1:0] res_word,
  output logic [1:0]                               res_byte
);

  localparam int WW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int DW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [WW-1:0] LAST_WORD = WW'(NWORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   drain_cnt, drain_cnt_nxt;
  logic            busy_nxt, done_nxt, op_valid_nxt, clr_cnt;
  logic [WW-1:0]   op_word_nxt;
  logic [1:0]      op_byte_nxt;

  logic [MUL_LAT-1:0] vld_pipe;
  logic [WW-1:0]      word_pipe [MUL_LAT];
  logic [1:0]         byte_pipe [MUL_LAT];

  // Next-state and next-output decode; abort overrides everything else.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    busy_nxt      = busy;
    done_nxt      = done;
    op_valid_nxt  = op_valid;
    op_word_nxt   = op_word;
    op_byte_nxt   = op_byte;
    clr_cnt       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_RUN;
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
          clr_cnt      = 1'b1;
          op_valid_nxt = 1'b1;
          op_word_nxt  = '0;
          op_byte_nxt  = '0;
        end
      end
      S_RUN: begin
        if (op_word == LAST_WORD && op_byte == 2'd3) begin
          state_nxt     = S_DRAIN;
          op_valid_nxt  = 1'b0;
          drain_cnt_nxt = DW'(MUL_LAT - 1);
        end else begin
          op_byte_nxt = op_byte + 2'd1;
          if (op_byte == 2'd3) op_word_nxt = op_word + WW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          drain_cnt_nxt = drain_cnt - DW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt     = S_IDLE;
      drain_cnt_nxt = drain_cnt;
      busy_nxt      = 1'b0;
      done_nxt      = done;
      op_valid_nxt  = 1'b0;
      op_word_nxt   = op_word;
      op_byte_nxt   = op_byte;
      clr_cnt       = 1'b0;
    end
  end

  // State and registered status/operand outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_valid  <= 1'b0;
      op_word   <= '0;
      op_byte   <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      op_valid  <= op_valid_nxt;
      op_word   <= op_word_nxt;
      op_byte   <= op_byte_nxt;
    end
  end

  // Job cycle counter: counts busy cycles, saturating, cleared on accepted start.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) cycle_cnt <= '0;
    else if (busy && cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
  end

  // Result pipeline mirrors the multiplier latency; abort flushes in-flight lanes.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      vld_pipe <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        word_pipe[i] <= '0;
        byte_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0]  <= op_valid;
      word_pipe[0] <= op_word;
      byte_pipe[0] <= op_byte;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        word_pipe[i] <= word_pipe[i-1];
        byte_pipe[i] <= byte_pipe[i-1];
      end
    end
  end

  assign res_we   = vld_pipe[MUL_LAT-1];
  assign res_word = word_pipe[MUL_LAT-1];
  assign res_byte = byte_pipe[MUL_LAT-1];

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Bench for accel_seq_ctrl: three instances (latency 1, latency 3, 4-bit
// saturating counter) share one start/abort/rst stream and are compared
// every cycle against a job-timeline reference model.
module tb_accel_seq_ctrl;

  localparam int NW = 4;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0;

  logic        busy [NI], done [NI], opv [NI], resw [NI];
  logic [1:0]  opw [NI], opb [NI], rw [NI], rb [NI];
  logic [15:0] cnt [NI];
  logic [3:0]  cnt_c;

  int n_chk = 0, n_err = 0, cyc = 0;

  int lat  [NI] = '{1, 3, 1};
  int cmax [NI] = '{65535, 65535, 15};

  // reference model state: k = index of the current job cycle (1 = first after start edge)
  bit act [NI], done_m [NI];
  int k [NI], cnt_m [NI], ow [NI], ob [NI];
  bit inited = 1'b0;

  always #5 clk = ~clk;

  accel_seq_ctrl #(.NWORDS(NW), .MUL_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy[0]), .done(done[0]), .cycle_cnt(cnt[0]),
    .op_valid(opv[0]), .op_word(opw[0]), .op_byte(opb[0]),
    .res_we(resw[0]), .res_word(rw[0]), .res_byte(rb[0]));

  accel_seq_ctrl #(.NWORDS(NW), .MUL_LAT(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy[1]), .done(done[1]), .cycle_cnt(cnt[1]),
    .op_valid(opv[1]), .op_word(opw[1]), .op_byte(opb[1]),
    .res_we(resw[1]), .res_word(rw[1]), .res_byte(rb[1]));

  accel_seq_ctrl #(.NWORDS(NW), .MUL_LAT(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy[2]), .done(done[2]), .cycle_cnt(cnt_c),
    .op_valid(opv[2]), .op_word(opw[2]), .op_byte(opb[2]),
    .res_we(resw[2]), .res_word(rw[2]), .res_byte(rb[2]));

  assign cnt[2] = {12'd0, cnt_c};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // advance the model across one rising edge with the inputs that edge samples
  task automatic model_edge(input bit s, input bit a, input bit r);
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        act[i] = 0; k[i] = 0; done_m[i] = 0; cnt_m[i] = 0; ow[i] = 0; ob[i] = 0;
      end else if (act[i]) begin
        cnt_m[i] = sat_inc(cnt_m[i], cmax[i]);
        if (a) act[i] = 0;
        else begin
          k[i]++;
          if (k[i] <= 4*NW) begin ow[i] = (k[i]-1)/4; ob[i] = (k[i]-1)%4; end
          if (k[i] > 4*NW + lat[i]) begin act[i] = 0; done_m[i] = 1; end
        end
      end else if (s && !a) begin
        act[i] = 1; k[i] = 1; done_m[i] = 0; cnt_m[i] = 0; ow[i] = 0; ob[i] = 0;
      end
    end
    inited = 1'b1;
    cyc++;
  endtask

  task automatic compare_all();
    bit ev, er;
    for (int i = 0; i < NI; i++) begin
      ev = act[i] && (k[i] <= 4*NW);
      er = act[i] && (k[i] > lat[i]) && (k[i] <= 4*NW + lat[i]);
      check_eq($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(act[i]));
      check_eq($sformatf("done[%0d]", i), 32'(done[i]), 32'(done_m[i]));
      check_eq($sformatf("cycle_cnt[%0d]", i), 32'(cnt[i]), 32'(cnt_m[i]));
      check_eq($sformatf("op_valid[%0d]", i), 32'(opv[i]), 32'(ev));
      check_eq($sformatf("op_idx[%0d]", i), {28'd0, opw[i], opb[i]}, 32'(ow[i]*4 + ob[i]));
      check_eq($sformatf("res_we[%0d]", i), 32'(resw[i]), 32'(er));
      if (er)
        check_eq($sformatf("res_idx[%0d]", i), {28'd0, rw[i], rb[i]}, 32'(k[i] - lat[i] - 1));
    end
  endtask

  task automatic step(input bit s, input bit a, input bit r);
    @(negedge clk);
    if (inited) compare_all();
    start = s; abort = a; rst = r;
    @(posedge clk);
    model_edge(s, a, r);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(0, 0, 0);
  endtask

  initial begin
    step(0, 0, 1);
    step(0, 0, 1);
    // clean job with a redundant start mid-run
    step(1, 0, 0);
    idle(3);
    step(1, 0, 0);
    idle(20);
    // restart after done, then abort mid-job
    step(1, 0, 0);
    idle(4);
    step(0, 1, 0);
    idle(3);
    // simultaneous start/abort in IDLE keeps done low here
    step(1, 1, 0);
    idle(2);
    // full job, then start+abort in IDLE with done high
    step(1, 0, 0);
    idle(22);
    step(1, 1, 0);
    idle(3);
    // reset mid-job
    step(1, 0, 0);
    idle(8);
    step(0, 0, 1);
    idle(3);
    // randomized traffic
    for (int j = 0; j < 4000; j++)
      step($urandom_range(0, 14) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 399) == 0);
    @(negedge clk);
    compare_all();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/accel_seq_ctrl.md
Name: accel_seq_ctrl

Overview:
- Sequencer for the crypto accelerator's shared 8-bit byte multiplier.
- On a go pulse from the MMIO register decode, walks all byte lanes of the key/plaintext words in order and issues one operand-select per cycle.
- Tracks the multiplier pipeline and emits matching result-write strobes for the cyphertext byte lanes.
- Drives the busy/done status bits and the cycle counter that software reads back through the status and counter registers.

Parameters:
- NWORDS, 4, number of 32-bit words per operand; 4 byte lanes each; range 1..8.
- MUL_LAT, 1, multiplier latency in cycles from operand select to product valid; range 1..4.
- CNT_W, 16, width of the cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  go pulse; write-enable & select & go-address decode.
- abort  in  1  cancel pulse from software.
- busy  out  1  high while a job is in RUN or DRAIN.
- done  out  1  sticky completion flag; cleared by the next accepted start.
- cycle_cnt  out  CNT_W  cycles spent in the last or current job.
- op_valid  out  1  operand indices valid this cycle.
- op_word  out  $clog2(NWORDS) (min 1)  word index to the key/plaintext muxes.
- op_byte  out  2  byte index within the word.
- res_we  out  1  cyphertext byte write strobe.
- res_word  out  $clog2(NWORDS) (min 1)  cyphertext word index for res_we.
- res_byte  out  2  cyphertext byte index for res_we.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, cycle_cnt=0, op_valid=0, op_word=0, op_byte=0, res_we=0, res_word=0, res_byte=0. The result pipeline is cleared.
- FSM states: IDLE, RUN, DRAIN. All outputs are registered.
- IDLE:
  - start=1 and abort=0 at edge T0 -> RUN.
  - At T0: done<=0, cycle_cnt<=0, op index<=0.
- RUN:
  - op_valid=1 every cycle.
  - Index order is op_byte 0,1,2,3, then op_byte wraps to 0 and op_word increments.
  - After issuing word NWORDS-1 / byte 3 -> DRAIN.
  - Issue count is exactly 4*NWORDS.
- DRAIN:
  - op_valid=0; op indices hold their last value.
  - Stays MUL_LAT cycles, then -> IDLE with done<=1, busy<=0.
- Result path:
  - res_we/res_word/res_byte equal op_valid/op_word/op_byte delayed by exactly MUL_LAT cycles through a shift pipeline.
  - res_we is 0 whenever the delayed op_valid is 0.
- Timing, with start sampled at edge 0:
  - op_valid is high cycles 1..4N (N=NWORDS).
  - res_we is high cycles 1+MUL_LAT..4N+MUL_LAT.
  - busy is high cycles 1..4N+MUL_LAT.
  - done=1 from cycle 4N+MUL_LAT+1.
  - Final cycle_cnt = 4N+MUL_LAT.
- cycle_cnt:
  - Increments by 1 every cycle busy=1.
  - Saturates at all-ones and never wraps.
  - Holds its value in IDLE.
- start while busy=1: ignored; no restart, no counter clear.
- abort:
  - From any state -> IDLE at the next edge; busy<=0, done unchanged.
  - op_valid<=0 and the whole result pipeline is flushed, so no res_we after the abort edge.
  - cycle_cnt holds its value.
- start and abort in the same cycle: abort wins; start is dropped.
- rst mid-job: behaves exactly as the reset row above; no res_we after the reset edge.
- done stays high across any number of IDLE cycles until the next accepted start.

Test Plan:
- Basic job, N=4, L=1: rst, then start pulse at edge 0 -> op_valid cycles 1..16 with (word,byte) = (0,0),(0,1)..(3,3); res_we cycles 2..17 with the same index sequence; busy 1..17; done=1 at cycle 18; cycle_cnt=17.
- Latency sweep, MUL_LAT=3: start -> first res_we at cycle 4, last at cycle 19; done at cycle 20; cycle_cnt=19; no res_we gaps.
- start re-pulsed at cycle 5 of a job -> sequence unchanged; done at cycle 18; cycle_cnt=17. A new start after done -> done drops next cycle and cycle_cnt restarts at 0.
- abort at cycle 6 -> busy=0 and op_valid=0 from cycle 7; no res_we from cycle 7; done stays 0; cycle_cnt=6.
- start and abort together in IDLE -> state stays IDLE, busy=0, done keeps its prior value.
- Saturation with CNT_W=4, N=4, L=1 -> cycle_cnt stops at 15; job still completes with done at cycle 18. Also rst=1 at cycle 9 -> all outputs 0 next cycle.
